pipe_monitor: RTL
=================

PIPE_MONITOR -- requirements
Module: pipe_monitor

Interface
REQ-001 SHALL provide parameter MAX_CYCLES, default 200; the cycle count at which a run stops.
REQ-002 SHALL provide parameter SPIN_LIMIT, default 8; the number of consecutive unchanged-PC, non-stall cycles that declares a halt.
REQ-003 SHALL provide port clk_i, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL provide port rst_i, input, 1 bit; the reset, asynchronous and active-high.
REQ-005 SHALL provide port start_i, input, 1 bit; the CPU start level, sampled each cycle.
REQ-006 SHALL provide port stall_i, input, 1 bit; high when the hazard unit holds PC and IF/ID this cycle.
REQ-007 SHALL provide port flush_i, input, 1 bit; high when IF/ID is flushed (branch/jump) this cycle.
REQ-008 SHALL provide port retire_i, input, 1 bit; high when a valid instruction leaves WB this cycle.
REQ-009 SHALL provide port pc_i, input, 32 bits; the current PC register value.
REQ-010 SHALL provide port rd_sel_i, input, 2 bits; counter select: 0 = cycles, 1 = stalls, 2 = flushes, 3 = retired.
REQ-011 SHALL provide port rd_data_o, output, 32 bits; the selected counter, combinational from the registered counters.
REQ-012 SHALL provide port state_o, output, 2 bits; the current FSM state encoding.
REQ-013 SHALL provide port done_o, output, 1 bit; high while the FSM is in DONE.
REQ-014 SHALL provide port halt_o, output, 1 bit; sticky, set when DONE was reached through spin detection.
REQ-015 SHALL provide port trace_idx_i, input, 3 bits; the flush-trace read index.
REQ-016 SHALL provide port trace_pc_o, output, 32 bits; the flush-trace read data.

Function
REQ-017 SHALL implement FSM states IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-018 SHALL transition IDLE->RUN on the first rising edge with start_i=1; counters do not increment in that transition cycle.
REQ-019 SHALL, in RUN, transition RUN->PAUSE when start_i=0; counters hold and the spin count clears.
REQ-020 SHALL transition PAUSE->RUN when start_i=1, with no counter clear.
REQ-021 SHALL, in RUN, increment the cycle counter by 1 every cycle.
REQ-022 SHALL, in RUN, increment the stall counter when stall_i=1, the flush counter when flush_i=1, and the retire counter when retire_i=1; simultaneous events each count independently.
REQ-023 SHALL make all counters 32-bit and saturating at 32'hFFFF_FFFF (no wrap).
REQ-024 SHALL keep a spin counter that increments when pc_i equals last cycle's registered PC and stall_i=0, and clears otherwise.
REQ-025 SHALL go RUN->DONE when the cycle counter reaches MAX_CYCLES-1 and increments, so the final cycle count equals MAX_CYCLES.
REQ-026 SHALL go RUN->DONE and set halt_o when the spin counter reaches SPIN_LIMIT.
REQ-027 SHALL, if both DONE conditions occur in the same cycle, set halt_o (halt takes priority).
REQ-028 SHALL make DONE absorbing until reset; start_i is ignored in DONE.
REQ-029 SHALL apply all counter updates with 1-cycle latency and update rd_data_o in the same cycle the selected counter changes.

Reset
REQ-030 SHALL, on rst_i=1, immediately force state IDLE and clear all counters, spin count, registered PC, halt_o, done_o, rd_data_o and all trace entries to 0.
REQ-031 SHALL, on reset mid-RUN, drop all accumulated counts; a new run requires start_i after rst_i falls.

Configuration
REQ-032 SHALL, with PIPE_MONITOR_TRACE_EN defined, provide an 8-entry circular buffer that records pc_i on each RUN cycle with flush_i=1: the write pointer advances modulo 8, the oldest entry is overwritten, and trace_pc_o = entry[(wptr-1-trace_idx_i) mod 8], with index 0 = most recent.
REQ-033 SHALL, without PIPE_MONITOR_TRACE_EN, build no buffer storage, drive trace_pc_o constant 0, and ignore trace_idx_i.

Structure
REQ-034 SHALL place the state encoding typedef, the rd_sel codes and the default MAX_CYCLES/SPIN_LIMIT constants in shared package cpu_pkg.
REQ-035 SHALL implement each counter as one instance of the sub-module sat_counter (32-bit saturating counter with enable and async clear).

Verification
REQ-036 SHALL cover: start_i=1 with no events for 200 cycles -> cycles=200, done_o=1, halt_o=0, other counters 0.
REQ-037 SHALL cover: stall_i and flush_i both high for 3 cycles in RUN -> stalls=3, flushes=3.
REQ-038 SHALL cover: pc_i held at 0x40 with stall_i=0 -> DONE and halt_o=1 after 8 spin cycles; pc_i held with stall_i=1 -> no halt.
REQ-039 SHALL cover: start_i dropped for 5 cycles mid-run -> state_o=2 and counters frozen; on resume counting continues from the frozen values.
REQ-040 SHALL cover: rst_i pulsed mid-RUN, asynchronous to clk_i -> all outputs 0 and state_o=0 before the next edge.
REQ-041 SHALL cover: with PIPE_MONITOR_TRACE_EN, 10 flushes at PCs 4,8,...,40 -> idx0=40, idx7=12 (entries for 4 and 8 overwritten).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline monitor: FSM state encoding, counter
// select codes and default run limits.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

    localparam logic [1:0] SEL_CYCLES  = 2'd0;
    localparam logic [1:0] SEL_STALLS  = 2'd1;
    localparam logic [1:0] SEL_FLUSHES = 2'd2;
    localparam logic [1:0] SEL_RETIRED = 2'd3;

    localparam int unsigned NUM_COUNTERS   = 4;
    localparam int unsigned DEF_MAX_CYCLES = 200;
    localparam int unsigned DEF_SPIN_LIMIT = 8;
    localparam int unsigned TRACE_DEPTH    = 8;

endpackage

// File: rtl/sat_counter.sv
// 32-bit event counter that sticks at all-ones instead of wrapping;
// cleared asynchronously by rst_i.
module sat_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_monitor.sv
// Pipeline performance monitor: run/pause/done FSM, four saturating event
// counters, PC spin (halt) detection. Flush-PC trace buffer built only when
// PIPE_MONITOR_TRACE_EN is defined.
module pipe_monitor
    import cpu_pkg::*;
#(
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int unsigned SPIN_LIMIT = DEF_SPIN_LIMIT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        retire_i,
    input  logic [31:0] pc_i,
    input  logic [1:0]  rd_sel_i,
    output logic [31:0] rd_data_o,
    output logic [1:0]  state_o,
    output logic        done_o,
    output logic        halt_o,
    input  logic [2:0]  trace_idx_i,
    output logic [31:0] trace_pc_o
);

    localparam int unsigned SPIN_W = $clog2(SPIN_LIMIT + 1);

    mon_state_e        state_q, state_d;
    logic [SPIN_W-1:0] spin_q, spin_d;
    logic [31:0]       pc_q;
    logic              halt_q, halt_d;
    logic              count_en;
    logic [NUM_COUNTERS-1:0] event_vec;
    logic [31:0]       cnt [NUM_COUNTERS];

    always_comb begin
        state_d  = state_q;
        spin_d   = '0;
        halt_d   = halt_q;
        count_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!start_i) begin
                    state_d = ST_PAUSE;
                end else begin
                    count_en = 1'b1;
                    if ((pc_i == pc_q) && !stall_i) begin
                        spin_d = spin_q + 1'b1;
                    end
                    // Spin halt is checked first so it wins over the cycle limit.
                    if (spin_d == SPIN_W'(SPIN_LIMIT)) begin
                        state_d = ST_DONE;
                        halt_d  = 1'b1;
                    end else if (cnt[SEL_CYCLES] == 32'(MAX_CYCLES - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (start_i) state_d = ST_RUN;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            spin_q  <= '0;
            pc_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            spin_q  <= spin_d;
            pc_q    <= pc_i;
            halt_q  <= halt_d;
        end
    end

    assign event_vec = {retire_i, flush_i, stall_i, 1'b1};

    for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_cnt
        sat_counter u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (count_en & event_vec[gi]),
            .count_o (cnt[gi])
        );
    end

    assign rd_data_o = cnt[rd_sel_i];
    assign state_o   = state_q;
    assign done_o    = (state_q == ST_DONE);
    assign halt_o    = halt_q;

`ifdef PIPE_MONITOR_TRACE_EN
    logic [2:0]  wptr_q;
    logic [2:0]  rd_ptr;
    logic [31:0] trace_q [TRACE_DEPTH];
    logic        trace_wr;

    assign trace_wr = count_en & flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
        end else if (trace_wr) begin
            wptr_q <= wptr_q + 3'd1;
        end
    end

    // Entries need an async clear, so they are plain flops rather than RAM.
    for (genvar gi = 0; gi < TRACE_DEPTH; gi++) begin : g_trace
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                trace_q[gi] <= '0;
            end else if (trace_wr && (wptr_q == 3'(gi))) begin
                trace_q[gi] <= pc_i;
            end
        end
    end

    assign rd_ptr     = wptr_q - 3'd1 - trace_idx_i;
    assign trace_pc_o = trace_q[rd_ptr];
`else
    logic trace_idx_unused;
    assign trace_idx_unused = ^trace_idx_i;
    assign trace_pc_o       = '0;
`endif

endmodule
